// File: rtl/ppr_pkg.sv
// Shared types and helpers for the PPR request collector/arbiter.
// The request-type encoding matches the per-channel fault tracker outputs.
package ppr_pkg;

    localparam int unsigned PPR_N_CH      = 32;
    localparam int unsigned PPR_ADDR_SIZE = 24;
    localparam int unsigned PPR_CH_W      = $clog2(PPR_N_CH);

    typedef enum logic [1:0] {
        PPR_NONE = 2'b00,
        PPR_SOFT = 2'b01,
        PPR_HARD = 2'b10,
        PPR_RSVD = 2'b11
    } ppr_type_e;

    typedef struct packed {
        ppr_type_e                  typ;
        logic [PPR_ADDR_SIZE-1:0]   addr;
        logic [PPR_CH_W-1:0]        ch;
    } ppr_req_t;

    function automatic logic ppr_is_req(ppr_type_e t);
        return (t == PPR_SOFT) || (t == PPR_HARD);
    endfunction

    // Class priority: hard wins over soft when two copies of a request combine.
    function automatic ppr_type_e ppr_merge(ppr_type_e a, ppr_type_e b);
        return ((a == PPR_HARD) || (b == PPR_HARD)) ? PPR_HARD : a;
    endfunction

endpackage

// File: rtl/ppr_rr_arb.sv
// Two-class round-robin arbiter: any hard request beats every soft one;
// within the winning class the search starts at ptr and wraps.
module ppr_rr_arb #(
    parameter int unsigned N_CH = 32
) (
    input  logic [N_CH-1:0]         req_hard,
    input  logic [N_CH-1:0]         req_soft,
    input  logic [$clog2(N_CH)-1:0] ptr,
    output logic [N_CH-1:0]         gnt,
    output logic                    gnt_valid,
    output logic [$clog2(N_CH)-1:0] gnt_idx,
    output logic [$clog2(N_CH)-1:0] next_ptr
);
    localparam int unsigned CH_W = $clog2(N_CH);

    logic [N_CH-1:0] sel;
    int unsigned     idx;

    always_comb begin
        sel       = (|req_hard) ? req_hard : req_soft;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = int'(unsigned'(ptr)) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!gnt_valid && sel[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = CH_W'(idx);
            end
        end
        gnt          = '0;
        gnt[gnt_idx] = gnt_valid;
        next_ptr     = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end

endmodule

// File: rtl/ppr_arb_queue.sv
// Multi-channel PPR request collector: one slot per channel, hard-first
// round-robin arbitration into an issue FIFO with valid/accept handshake.
module ppr_arb_queue
    import ppr_pkg::*;
#(
    parameter int unsigned N_CH      = 32,
    parameter int unsigned ADDR_SIZE = 24,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_CH-1:0]                  ppr_valid_i,
    input  logic [N_CH-1:0][1:0]             ppr_type_i,
    input  logic [N_CH-1:0][ADDR_SIZE-1:0]   ppr_addr_i,
    output logic [N_CH-1:0]                  ppr_ready_o,
    output logic                             ppr_valid_o,
    input  logic                             ppr_cmd_i,
    output logic [1:0]                       ppr_type_o,
    output logic [ADDR_SIZE-1:0]             ppr_addr_o,
    output logic [$clog2(N_CH)-1:0]          ppr_ch_o,
    output logic [N_CH-1:0]                  ppr_done_o,
    output logic [$clog2(DEPTH):0]           ppr_q_cnt_o,
    output logic [CNT_W-1:0]                 ppr_drop_cnt_o,
    output logic                             ppr_busy_o
);
    localparam int unsigned CH_W = $clog2(N_CH);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned QW   = AW + 1;
    localparam int unsigned PW   = $clog2(N_CH + 1);

    typedef struct packed {
        ppr_type_e              typ;
        logic [ADDR_SIZE-1:0]   addr;
        logic [CH_W-1:0]        ch;
    } entry_t;

    logic [N_CH-1:0]            slot_v;
    ppr_type_e                  slot_typ  [N_CH];
    logic [ADDR_SIZE-1:0]       slot_addr [N_CH];
    ppr_type_e                  in_typ    [N_CH];
    logic [N_CH-1:0]            in_ok, merge, drop, req_hard, req_soft, gnt;
    logic                       gnt_valid, can_push, push, pop;
    logic [CH_W-1:0]            gnt_idx, next_ptr, rr_ptr;
    entry_t                     push_e, head;
    entry_t                     mem [DEPTH];
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [QW-1:0]              q_cnt;
    logic [PW-1:0]              drop_n;
    logic [CNT_W:0]             drop_sum;
    logic [CNT_W-1:0]           drop_cnt;
    logic [N_CH-1:0]            done_r;

    always_comb begin
        can_push = (q_cnt < QW'(DEPTH));
        drop_n   = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            in_typ[c]   = ppr_type_e'(ppr_type_i[c]);
            in_ok[c]    = ppr_valid_i[c] && ppr_is_req(in_typ[c]);
            merge[c]    = in_ok[c] && slot_v[c] && (slot_addr[c] == ppr_addr_i[c]);
            drop[c]     = (ppr_valid_i[c] && (in_typ[c] == PPR_RSVD)) ||
                          (in_ok[c] && slot_v[c] && (slot_addr[c] != ppr_addr_i[c]));
            req_hard[c] = can_push && slot_v[c] && (slot_typ[c] == PPR_HARD);
            req_soft[c] = can_push && slot_v[c] && (slot_typ[c] != PPR_HARD);
            drop_n      = drop_n + PW'(drop[c]);
        end
        drop_sum = {1'b0, drop_cnt} + (CNT_W + 1)'(drop_n);
    end

    ppr_rr_arb #(.N_CH(N_CH)) u_arb (
        .req_hard  (req_hard),
        .req_soft  (req_soft),
        .ptr       (rr_ptr),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .next_ptr  (next_ptr)
    );

    // A request merging into the slot being granted upgrades the pushed copy,
    // since the slot itself is cleared at the same edge.
    always_comb begin
        push        = gnt_valid;
        push_e.typ  = ppr_merge(slot_typ[gnt_idx], merge[gnt_idx] ? in_typ[gnt_idx] : PPR_NONE);
        push_e.addr = slot_addr[gnt_idx];
        push_e.ch   = gnt_idx;
        pop         = (q_cnt != '0) && ppr_cmd_i;
        head        = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v   <= '0;
            rr_ptr   <= '0;
            drop_cnt <= '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                slot_typ[c]  <= PPR_NONE;
                slot_addr[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (gnt[c]) begin
                    slot_v[c] <= 1'b0;
                end else if (slot_v[c]) begin
                    if (merge[c]) slot_typ[c] <= ppr_merge(slot_typ[c], in_typ[c]);
                end else if (in_ok[c]) begin
                    slot_v[c]    <= 1'b1;
                    slot_typ[c]  <= in_typ[c];
                    slot_addr[c] <= ppr_addr_i[c];
                end
            end
            if (gnt_valid) rr_ptr <= next_ptr;
            drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_e;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
            done_r <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   q_cnt <= q_cnt + QW'(1);
                2'b01:   q_cnt <= q_cnt - QW'(1);
                default: q_cnt <= q_cnt;
            endcase
            done_r <= pop ? (N_CH'(1) << head.ch) : '0;
        end
    end

    assign ppr_ready_o    = ~slot_v;
    assign ppr_valid_o    = (q_cnt != '0);
    assign ppr_type_o     = ppr_valid_o ? head.typ  : 2'b00;
    assign ppr_addr_o     = ppr_valid_o ? head.addr : '0;
    assign ppr_ch_o       = ppr_valid_o ? head.ch   : '0;
    assign ppr_done_o     = done_r;
    assign ppr_q_cnt_o    = q_cnt;
    assign ppr_drop_cnt_o = drop_cnt;
    assign ppr_busy_o     = (|slot_v) || (q_cnt != '0);

endmodule
